// File: rtl/rotate_right_seq.sv
// rotate_right_seq: multi-cycle right rotator / shifter (ROR, SRL, SRA).
// One binary-weighted stage per clock, valid/ready on both sides.
module rotate_right_seq #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [CNT_W-1:0] in_cnt,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  localparam int KW = (CNT_W > 1) ? $clog2(CNT_W) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(CNT_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] work_q;
  logic [WIDTH-1:0] work_d;
  logic [WIDTH-1:0] shifted;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       op_q;
  logic [KW-1:0]    k_q;
  logic             rdy_q;
  logic             vld_q;
  logic [WIDTH-1:0] res_q;
  logic             is_ror;
  logic             fill;
  int               amt;
  int               src;

  assign in_ready  = rdy_q;
  assign out_valid = vld_q;
  assign out_data  = res_q;

  // One stage: shift the working word right by 2^k when cnt bit k is set.
  // SRA fills from the current MSB, which every SRA stage preserves.
  always_comb begin
    is_ror  = (op_q == 2'b00) || (op_q == 2'b11);
    fill    = (op_q == 2'b10) ? work_q[WIDTH-1] : 1'b0;
    amt     = 1 << k_q;
    src     = 0;
    shifted = '0;
    for (int i = 0; i < WIDTH; i++) begin
      src = i + amt;
      if (src < WIDTH) begin
        shifted[i] = work_q[src];
      end else if (is_ror) begin
        shifted[i] = work_q[src-WIDTH];
      end else begin
        shifted[i] = fill;
      end
    end
    work_d = cnt_q[k_q] ? shifted : work_q;
  end

  // Control FSM with registered handshake outputs; in_ready mirrors IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      k_q     <= '0;
      rdy_q   <= 1'b1;
      vld_q   <= 1'b0;
      res_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            work_q  <= in_data;
            cnt_q   <= in_cnt;
            op_q    <= in_op;
            k_q     <= '0;
            rdy_q   <= 1'b0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          work_q <= work_d;
          k_q    <= k_q + 1'b1;
          if (k_q == K_LAST) begin
            res_q   <= work_d;
            vld_q   <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            vld_q   <= 1'b0;
            rdy_q   <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: begin
          vld_q   <= 1'b0;
          rdy_q   <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/rotate_right_seq.md
Name: rotate_right_seq

Overview:
- Multi-cycle 16-bit right rotator/shifter for the ALU shift path.
- The counterpart direction to the existing left-rotate stages. Handles ROR, SRL and SRA by a 4-bit amount.
- Applies one binary-weighted stage (1, 2, 4, 8) per clock under a small FSM.
- Uses valid/ready handshakes on both sides so the ALU control can stall it.

Parameters:
WIDTH, 16, data width in bits; must be a power of two
CNT_W, 4, shift-amount width; equals log2(WIDTH); also the number of stage cycles

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  reset, synchronous and active-low
in_valid  input  1  request valid; in_data, in_cnt and in_op are sampled when in_valid and in_ready are both high
in_ready  output  1  block can accept a request
in_data  input  WIDTH  operand
in_cnt  input  CNT_W  shift/rotate amount, 0..WIDTH-1
in_op  input  2  00=ROR, 01=SRL, 10=SRA, 11=ROR (alias)
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_data  output  WIDTH  result

Behaviour:
- FSM states: IDLE, SHIFT, DONE. Encoding is free.
- Reset (rst_n low at a rising edge):
  - state=IDLE, working register=0, stage index=0, out_valid=0, out_data=0.
  - in_ready is high from the first cycle after reset.
  - Reset mid-operation aborts the operation; the result is discarded and never presented.
- in_ready = (state==IDLE). It is purely a state decode, with no combinational path from in_valid.
- IDLE:
  - On in_valid & in_ready, capture data into the working register, and capture cnt and op.
  - Clear stage index k=0 and go to SHIFT.
- SHIFT, one edge per stage k (0..CNT_W-1):
  - If cnt[k]=1, the working register is replaced by its shift by 2^k; otherwise it is held.
  - ROR: bits leaving bit 0 re-enter at bit WIDTH-1.
  - SRL: vacated MSBs are filled with 0.
  - SRA: vacated MSBs are filled with the captured operand's bit WIDTH-1. Because every SRA stage preserves the MSB, the current MSB may equally be used.
  - k increments each edge. On the edge where k==CNT_W-1 the final stage is applied and the state goes to DONE.
- Latency is fixed regardless of cnt, including cnt=0:
  - accept on edge T; stages on edges T+1..T+CNT_W;
  - out_valid is high in the cycle following edge T+CNT_W (4 cycles after accept at default parameters).
- DONE:
  - out_valid=1 and out_data = working register.
  - out_data holds stable until the handshake completes.
  - On out_ready=1, go to IDLE at that edge; out_valid drops next cycle.
- out_data outside DONE: holds the last result; its value is not checked when out_valid=0.
- in_valid while not IDLE: ignored, with no capture. The upstream producer holds its request until in_ready.
- Throughput: at most one operation per CNT_W+2 cycles. No back-to-back overlap: a new accept can occur only in the cycle after the DONE handshake.
- out_ready high while not in DONE has no effect.
- All arithmetic is modulo WIDTH bits. in_cnt is never out of range by construction.

Test Plan:
- ROR, in_data=16'h1234, in_cnt=4 → out_data=16'h4123; out_valid rises exactly 4 cycles after the accept edge; in_ready=0 throughout.
- ROR 16'h8001 cnt=1 → 16'hC000. ROR 16'h0001 cnt=15 → 16'h0002. Op 11 with 16'h8001 cnt=1 → 16'hC000.
- SRL 16'h8000 cnt=15 → 16'h0001. SRA 16'h8000 cnt=15 → 16'hFFFF. SRA 16'h7FF0 cnt=4 → 16'h07FF.
- cnt=0, ROR/SRL/SRA with 16'hBEEF → 16'hBEEF each, with the same 4-cycle latency.
- Backpressure: hold out_ready=0 for 3 cycles in DONE while toggling in_valid with new data.
  - out_valid stays 1; out_data stays stable; in_ready stays 0; no new capture occurs.
  - After out_ready=1, the next request is accepted one cycle later.
- Pulse rst_n low during the second SHIFT cycle → next cycle: state IDLE, out_valid=0, in_ready=1, out_data=0. The aborted result never appears, and a fresh request completes normally.
